// File: rtl/ram_arbiter_pkg.sv
// Shared types, requester ids and helpers for the two-port RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  // Each set strobe bit enables a full byte lane of the RAM write mask.
  function automatic logic [31:0] expand_wstrb(input logic [3:0] wstrb);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{wstrb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the side not granted last wins.
module ram_rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       valid_o,
  output logic       gnt_id_o
);

  logic last_q;
  logic last_d;

  // Pick the winner and advance the last-grant pointer whenever a grant is issued
  always_comb begin
    gnt_id_o = INST;
    if (req_i[INST] && req_i[DATA]) begin
      gnt_id_o = ~last_q;
    end else if (req_i[DATA]) begin
      gnt_id_o = DATA;
    end
    valid_o = en_i && (|req_i);
    last_d  = last_q;
    if (valid_o) begin
      last_d = gnt_id_o;
    end
  end

  // Pointer starts at DATA so that the instruction side wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= DATA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAMHelper-style memory between an instruction and a data port,
// one outstanding transaction at a time, with an optional response delay.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DELAY     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic [3:0]  inst_wstrb,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [31:0] ram_ridx,
  output logic [31:0] ram_widx,
  output logic [31:0] ram_wdata,
  output logic [31:0] ram_wmask,
  output logic        ram_wen,
  input  logic [31:0] ram_rdata
);

  localparam logic [3:0] DELAY_CNT = DELAY[3:0];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        owner_q, owner_d;

  logic        grant;
  logic        gnt_id;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_idx;

  ram_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({data_req, inst_req}),
    .en_i     ((state_q == IDLE) && !rst),
    .valid_o  (grant),
    .gnt_id_o (gnt_id)
  );

  // Route the granted side's payload to the memory and form its word index
  always_comb begin
    sel_wr    = inst_wr;
    sel_addr  = inst_addr;
    sel_wdata = inst_wdata;
    sel_wstrb = inst_wstrb;
    if (gnt_id == DATA) begin
      sel_wr    = data_wr;
      sel_addr  = data_addr;
      sel_wdata = data_wdata;
      sel_wstrb = data_wstrb;
    end
    sel_idx = (sel_addr - BASE_ADDR) >> 2;
  end

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      owner_q <= INST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
    end
  end

  // Next state: a grant captures read data and owner, then WAIT counts the delay down
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = WAIT;
          cnt_d   = DELAY_CNT;
          rdata_d = ram_rdata;
          owner_d = gnt_id;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory port live only in the grant cycle, data_ok once the count expires
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    ram_en       = 1'b0;
    ram_wen      = 1'b0;
    ram_ridx     = '0;
    ram_widx     = '0;
    ram_wdata    = '0;
    ram_wmask    = '0;
    inst_rdata   = rdata_q;
    data_rdata   = rdata_q;
    if (grant) begin
      inst_addr_ok = (gnt_id == INST);
      data_addr_ok = (gnt_id == DATA);
      ram_en       = 1'b1;
      ram_wen      = sel_wr;
      ram_ridx     = sel_idx;
      ram_widx     = sel_idx;
      ram_wdata    = sel_wdata;
      ram_wmask    = expand_wstrb(sel_wstrb);
    end
    if ((state_q == WAIT) && (cnt_q == 4'd0) && !rst) begin
      inst_data_ok = (owner_q == INST);
      data_data_ok = (owner_q == DATA);
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three instances with different BASE_ADDR/DELAY settings,
// a timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_ram_arbiter;

  logic clk;

  logic        rst        [3];
  logic        instReq    [3];
  logic        instWr     [3];
  logic [31:0] instAddr   [3];
  logic [31:0] instWdata  [3];
  logic [3:0]  instWstrb  [3];
  logic        instAddrOk [3];
  logic        instDataOk [3];
  logic [31:0] instRdata  [3];
  logic        dataReq    [3];
  logic        dataWr     [3];
  logic [31:0] dataAddr   [3];
  logic [31:0] dataWdata  [3];
  logic [3:0]  dataWstrb  [3];
  logic        dataAddrOk [3];
  logic        dataDataOk [3];
  logic [31:0] dataRdata  [3];
  logic        ramEn      [3];
  logic [31:0] ramRidx    [3];
  logic [31:0] ramWidx    [3];
  logic [31:0] ramWdata   [3];
  logic [31:0] ramWmask   [3];
  logic        ramWen     [3];
  logic [31:0] ramRdata   [3];

  int checks   = 0;
  int failures = 0;
  bit compEn   = 0;

  // Reference model state per instance, expressed as cycle timestamps
  int          cyc       [3];
  int          freeAt    [3];
  int          dataOkAt  [3];
  bit          owner     [3];
  bit          lastGrant [3];
  logic [31:0] rdExp     [3];

  // Memory contents seen by each instance: word 4 is special, others are a pattern
  function automatic logic [31:0] memFn(input logic [31:0] idx);
    if (idx == 32'd4) return 32'hDEAD_BEEF;
    return (idx * 32'h0101_0101) ^ 32'hC3C3_0000;
  endfunction

  function automatic logic [31:0] baseOf(input int g);
    return (g == 1) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

  function automatic int delayOf(input int g);
    return (g == 1) ? 3 : ((g == 2) ? 2 : 0);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    ram_arbiter #(
      .BASE_ADDR ((g == 1) ? 32'h8000_0000 : 32'h0000_0000),
      .DELAY     ((g == 1) ? 3 : ((g == 2) ? 2 : 0))
    ) dut (
      .clk          (clk),
      .rst          (rst[g]),
      .inst_req     (instReq[g]),
      .inst_wr      (instWr[g]),
      .inst_addr    (instAddr[g]),
      .inst_wdata   (instWdata[g]),
      .inst_wstrb   (instWstrb[g]),
      .inst_addr_ok (instAddrOk[g]),
      .inst_data_ok (instDataOk[g]),
      .inst_rdata   (instRdata[g]),
      .data_req     (dataReq[g]),
      .data_wr      (dataWr[g]),
      .data_addr    (dataAddr[g]),
      .data_wdata   (dataWdata[g]),
      .data_wstrb   (dataWstrb[g]),
      .data_addr_ok (dataAddrOk[g]),
      .data_data_ok (dataDataOk[g]),
      .data_rdata   (dataRdata[g]),
      .ram_en       (ramEn[g]),
      .ram_ridx     (ramRidx[g]),
      .ram_widx     (ramWidx[g]),
      .ram_wdata    (ramWdata[g]),
      .ram_wmask    (ramWmask[g]),
      .ram_wen      (ramWen[g]),
      .ram_rdata    (ramRdata[g])
    );
    assign ramRdata[g] = memFn(ramRidx[g]);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int g, input logic ir, input logic iw, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dws);
    instReq[g]   = ir;
    instWr[g]    = iw;
    instAddr[g]  = ia;
    instWdata[g] = 32'hCAFE_0001;
    instWstrb[g] = 4'hF;
    dataReq[g]   = dr;
    dataWr[g]    = dw;
    dataAddr[g]  = da;
    dataWdata[g] = dwd;
    dataWstrb[g] = dws;
  endtask

  task automatic modelReset(input int g);
    cyc[g]       = 0;
    freeAt[g]    = 0;
    dataOkAt[g]  = -1;
    owner[g]     = 1'b0;
    lastGrant[g] = 1'b1;
    rdExp[g]     = '0;
  endtask

  // Compare one instance against the model for the current cycle, then advance the model
  task automatic compareInst(input int g);
    logic        grantOk, id, wr;
    logic [31:0] addr, idx, wd, wm;
    logic [3:0]  strb;
    string       p;
    p = $sformatf("g%0d ", g);
    if (rst[g]) begin
      modelReset(g);
      checkOutput({p, "rst inst_addr_ok"}, {31'd0, instAddrOk[g]}, 32'd0);
      checkOutput({p, "rst data_addr_ok"}, {31'd0, dataAddrOk[g]}, 32'd0);
      checkOutput({p, "rst inst_data_ok"}, {31'd0, instDataOk[g]}, 32'd0);
      checkOutput({p, "rst data_data_ok"}, {31'd0, dataDataOk[g]}, 32'd0);
      checkOutput({p, "rst ram_en"},       {31'd0, ramEn[g]},      32'd0);
      checkOutput({p, "rst ram_wen"},      {31'd0, ramWen[g]},     32'd0);
      checkOutput({p, "rst ram_ridx"},     ramRidx[g],             32'd0);
      checkOutput({p, "rst ram_wmask"},    ramWmask[g],            32'd0);
      checkOutput({p, "rst inst_rdata"},   instRdata[g],           32'd0);
      checkOutput({p, "rst data_rdata"},   dataRdata[g],           32'd0);
      return;
    end
    grantOk = (cyc[g] >= freeAt[g]) && (instReq[g] || dataReq[g]);
    id      = (instReq[g] && dataReq[g]) ? ~lastGrant[g] : dataReq[g];
    addr    = id ? dataAddr[g]  : instAddr[g];
    wd      = id ? dataWdata[g] : instWdata[g];
    strb    = id ? dataWstrb[g] : instWstrb[g];
    wr      = id ? dataWr[g]    : instWr[g];
    idx     = (addr - baseOf(g)) / 32'd4;
    wm      = '0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) wm = wm | (32'hFF << (8 * b));
    end
    checkOutput({p, "inst_addr_ok"}, {31'd0, instAddrOk[g]}, {31'd0, grantOk && !id});
    checkOutput({p, "data_addr_ok"}, {31'd0, dataAddrOk[g]}, {31'd0, grantOk && id});
    checkOutput({p, "inst_data_ok"}, {31'd0, instDataOk[g]}, {31'd0, (cyc[g] == dataOkAt[g]) && !owner[g]});
    checkOutput({p, "data_data_ok"}, {31'd0, dataDataOk[g]}, {31'd0, (cyc[g] == dataOkAt[g]) && owner[g]});
    checkOutput({p, "inst_rdata"},   instRdata[g], rdExp[g]);
    checkOutput({p, "data_rdata"},   dataRdata[g], rdExp[g]);
    checkOutput({p, "ram_en"},       {31'd0, ramEn[g]},  {31'd0, grantOk});
    checkOutput({p, "ram_wen"},      {31'd0, ramWen[g]}, {31'd0, grantOk && wr});
    checkOutput({p, "ram_ridx"},     ramRidx[g],  grantOk ? idx : 32'd0);
    checkOutput({p, "ram_widx"},     ramWidx[g],  grantOk ? idx : 32'd0);
    checkOutput({p, "ram_wdata"},    ramWdata[g], grantOk ? wd  : 32'd0);
    checkOutput({p, "ram_wmask"},    ramWmask[g], grantOk ? wm  : 32'd0);
    if (grantOk) begin
      lastGrant[g] = id;
      owner[g]     = id;
      rdExp[g]     = memFn(idx);
      dataOkAt[g]  = cyc[g] + 1 + delayOf(g);
      freeAt[g]    = cyc[g] + 2 + delayOf(g);
    end
    cyc[g]++;
  endtask

  // Single compare process: every instance checked on every falling edge
  always @(negedge clk) begin
    if (compEn) begin
      for (int g = 0; g < 3; g++) compareInst(g);
    end
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1;
      applyStimulus(g, 0, 0, 0, 0, 0, 0, 0, 0);
      modelReset(g);
    end
    tick();
    compEn = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    tick();

    // Instruction read of word 4 with no delay
    applyStimulus(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("read ram_ridx", ramRidx[0], 32'd4);
    checkOutput("read inst_addr_ok", {31'd0, instAddrOk[0]}, 32'd1);
    checkOutput("read ram_en", {31'd0, ramEn[0]}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("read inst_data_ok", {31'd0, instDataOk[0]}, 32'd1);
    checkOutput("read inst_rdata", instRdata[0], 32'hDEAD_BEEF);
    checkOutput("read inst_addr_ok low", {31'd0, instAddrOk[0]}, 32'd0);
    tick();

    // Data write with partial strobes
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'h1122_3344, 4'b0101);
    @(negedge clk);
    checkOutput("write ram_widx", ramWidx[0], 32'd8);
    checkOutput("write ram_wmask", ramWmask[0], 32'h00FF_00FF);
    checkOutput("write ram_wdata", ramWdata[0], 32'h1122_3344);
    checkOutput("write ram_wen", {31'd0, ramWen[0]}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("write ram_wen after", {31'd0, ramWen[0]}, 32'd0);
    checkOutput("write data_data_ok", {31'd0, dataDataOk[0]}, 32'd1);
    tick();

    // Both sides requesting from reset release alternate, starting with inst
    rst[0] = 1'b1;
    applyStimulus(0, 1, 0, 32'h40, 1, 0, 32'h44, 0, 0);
    tick();
    tick();
    rst[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr inst_addr_ok k%0d", k), {31'd0, instAddrOk[0]}, {31'd0, (k % 4) == 0});
      checkOutput($sformatf("rr data_addr_ok k%0d", k), {31'd0, dataAddrOk[0]}, {31'd0, (k % 4) == 2});
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // DELAY=3 data read with offset base, inst waits then hits the wrapped index
    applyStimulus(1, 0, 0, 0, 1, 0, 32'h8000_0100, 0, 0);
    @(negedge clk);
    checkOutput("delay3 data_addr_ok", {31'd0, dataAddrOk[1]}, 32'd1);
    checkOutput("delay3 ram_ridx", ramRidx[1], 32'h0000_0040);
    tick();
    applyStimulus(1, 1, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checkOutput($sformatf("delay3 data_data_ok T+%0d", j), {31'd0, dataDataOk[1]}, 32'd0);
      checkOutput($sformatf("delay3 inst_addr_ok T+%0d", j), {31'd0, instAddrOk[1]}, 32'd0);
      tick();
    end
    @(negedge clk);
    checkOutput("delay3 data_data_ok T+4", {31'd0, dataDataOk[1]}, 32'd1);
    checkOutput("delay3 data_rdata", dataRdata[1], 32'h8383_4040);
    checkOutput("delay3 inst_addr_ok T+4", {31'd0, instAddrOk[1]}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("delay3 inst_addr_ok T+5", {31'd0, instAddrOk[1]}, 32'd1);
    checkOutput("wrap ram_ridx", ramRidx[1], 32'h2000_0000);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) tick();

    // Reset pulsed mid-transaction aborts it; inst still wins the next tie
    applyStimulus(2, 1, 0, 32'h8, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("abort inst_addr_ok", {31'd0, instAddrOk[2]}, 32'd1);
    tick();
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0);
    rst[2] = 1'b1;
    @(negedge clk);
    checkOutput("abort rst inst_data_ok", {31'd0, instDataOk[2]}, 32'd0);
    checkOutput("abort rst inst_rdata", instRdata[2], 32'd0);
    tick();
    rst[2] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checkOutput($sformatf("abort no data_ok c%0d", j), {31'd0, instDataOk[2]}, 32'd0);
      tick();
    end
    applyStimulus(2, 1, 0, 32'hC, 1, 0, 32'h14, 0, 0);
    @(negedge clk);
    checkOutput("abort tie inst_addr_ok", {31'd0, instAddrOk[2]}, 32'd1);
    checkOutput("abort tie data_addr_ok", {31'd0, dataAddrOk[2]}, 32'd0);
    tick();
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 6; j++) tick();

    compEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address mapped to RAMHelper word index 0.
REQ-002 Parameter DELAY, default 0, range 0..15: extra wait cycles inserted before each data_ok.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 inst_req, inst_wr  in  1 each  instruction-side request valid and write flag.
REQ-006 inst_addr, inst_wdata  in  32 each  byte address and write data; inst_wstrb  in  4  byte strobes.
REQ-007 inst_addr_ok, inst_data_ok  out  1 each  request accepted; response valid. inst_rdata  out  32  read data.
REQ-008 data_req, data_wr, data_addr, data_wdata, data_wstrb, data_addr_ok, data_data_ok, data_rdata: same widths and meanings as the inst_* ports.
REQ-009 ram_en  out  1; ram_ridx, ram_widx, ram_wdata, ram_wmask  out  32 each; ram_wen  out  1; ram_rdata  in  32 (combinational from ram_ridx).

Function
REQ-010 FSM states: IDLE and WAIT only.
REQ-011 IDLE with at least one req high: grant exactly one requester, drive its addr_ok=1 for that cycle, then go to WAIT.
REQ-012 Arbitration: round-robin; when both request, grant the side not granted last; the last-grant pointer updates on every grant.
REQ-013 Grant cycle: ram_en=1, ram_ridx=ram_widx=(addr-BASE_ADDR)>>2, ram_wdata=wdata, ram_wmask expands wstrb[i] to 8'hFF in byte i, ram_wen=wr.
REQ-014 Outside the grant cycle: ram_en=0 and ram_wen=0; index, data and mask outputs are 0.
REQ-015 Grant-cycle rising edge: capture ram_rdata into rdata_q, the granted id into owner_q, and load counter cnt=DELAY.
REQ-016 WAIT with cnt!=0: decrement cnt; no addr_ok and no data_ok.
REQ-017 WAIT with cnt==0: owner's data_ok=1 for exactly one cycle, then return to IDLE; the other side's data_ok stays 0.
REQ-018 Timing: addr_ok in cycle T gives data_ok in cycle T+1+DELAY; earliest next grant is T+2+DELAY.
REQ-019 inst_rdata and data_rdata both drive rdata_q; a read returns the memory value at the grant cycle; a write returns don't-care data but still produces data_ok.
REQ-020 The non-granted requester gets addr_ok=0 and must hold its req and payload; no requests are queued internally.
REQ-021 addr_ok never asserts in WAIT, so at most one transaction is outstanding.
REQ-022 A req deasserted before its grant is dropped silently; addr_ok and data_ok are never both high for the same requester in one cycle.
REQ-023 Address wrap: the subtraction is modulo 2^32; there is no range check.

Reset
REQ-024 rst=1 forces state=IDLE, cnt=0, rdata_q=0, owner_q=inst, and last-grant pointer=data (inst wins the first tie).
REQ-025 During reset all outputs are 0, including ram_en and ram_wen.
REQ-026 Reset asserted during WAIT aborts the transaction; its data_ok is never issued; a write already committed stays committed.

Structure
REQ-027 Shared package holds the state enum (IDLE, WAIT), requester-id constants (INST=0, DATA=1) and the wstrb-to-wmask expansion function.
REQ-028 One sub-module, ram_rr_arb2: a 2-way round-robin arbiter with pointer; FSM and datapath stay in ram_arbiter.

Verification
REQ-029 DELAY=0, inst read addr 0x10 while memory word 4 holds 0xDEADBEEF -> ram_ridx=4, inst_addr_ok at T, inst_data_ok at T+1, inst_rdata=0xDEADBEEF.
REQ-030 Both req held from reset release -> grants alternate inst, data, inst, data; each addr_ok two cycles after the previous one.
REQ-031 data write addr 0x20, wdata 0x11223344, wstrb 4'b0101 -> ram_widx=8, ram_wmask=0x00FF00FF, ram_wen=1 for one cycle only; data_ok one cycle later.
REQ-032 DELAY=3, data read -> data_ok at T+4; inst req raised at T+1 gets addr_ok at T+5.
REQ-033 BASE_ADDR=0x8000_0000, addr 0x8000_0100 -> index 0x40; addr 0x0000_0000 -> index 0x2000_0000 (wrap).
REQ-034 rst pulsed at T+1 of a DELAY=2 read -> no data_ok afterwards, all outputs 0, and the next request is granted normally with inst winning the tie.
